// File: rtl/cpu_bus_pkg.sv
// Shared types and bit positions for the CPU-bus instruction loader.
package cpu_bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Control word bit positions (write to the all-ones bus address)
    localparam int CTRL_START    = 0;
    localparam int CTRL_IRQ_CLR  = 1;
    localparam int CTRL_PROG_CLR = 2;
    localparam int CTRL_ERR_CLR  = 3;

    // cpu_status bit positions: {err, busy, done, prog_valid}
    localparam int STAT_PROG_VALID = 0;
    localparam int STAT_DONE       = 1;
    localparam int STAT_BUSY       = 2;
    localparam int STAT_ERR        = 3;

    // Width of the beat-index field; at least one bit even for single-beat instructions
    function automatic int beat_bits(input int beats);
        return (beats <= 1) ? 1 : $clog2(beats);
    endfunction

endpackage

// File: rtl/instr_assembler.sv
// Collects bus beats into a full instruction and issues one registered IMEM write
// when the top beat arrives. Lower beats may come in any order and be rewritten.
module instr_assembler
    import cpu_bus_pkg::*;
#(
    parameter int BUS_W   = 32,
    parameter int INSTR_W = 64,
    parameter int IDX_W   = 8,
    localparam int BEATS    = INSTR_W / BUS_W,
    localparam int BEAT_BIT = beat_bits(BEATS)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                beat_wr,
    input  logic [BEAT_BIT-1:0] beat_idx,
    input  logic [IDX_W-1:0]    instr_idx,
    input  logic [BUS_W-1:0]    beat_data,
    input  logic                mask_clr,
    output logic                commit,
    output logic                incomplete,
    output logic                imem_we,
    output logic [IDX_W-1:0]    imem_waddr,
    output logic [INSTR_W-1:0]  imem_wdata
);

    logic [BEATS-1:0][BUS_W-1:0] beat_buf;
    logic [BEATS-1:0][BUS_W-1:0] merged;
    logic [BEATS-1:0]            mask;
    logic                        in_range;
    logic                        last_beat;
    logic                        mask_full;

    // Beat decode; the top beat is implicitly present when it triggers the write
    always_comb begin
        in_range   = (32'(beat_idx) < BEATS);
        last_beat  = (32'(beat_idx) == BEATS - 1);
        mask_full  = &(mask | (BEATS'(1) << (BEATS - 1)));
        commit     = beat_wr && in_range && last_beat;
        incomplete = commit && !mask_full;
        merged     = beat_buf;
        if (in_range) begin
            merged[beat_idx] = beat_data;
        end
    end

    // Beat buffer, presence mask and registered IMEM write port
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_buf   <= '0;
            mask       <= '0;
            imem_we    <= 1'b0;
            imem_waddr <= '0;
            imem_wdata <= '0;
        end else begin
            imem_we <= 1'b0;
            if (mask_clr) begin
                mask <= '0;
            end
            if (beat_wr && in_range) begin
                beat_buf[beat_idx] <= beat_data;
                if (last_beat) begin
                    mask       <= '0;
                    imem_we    <= 1'b1;
                    imem_waddr <= instr_idx;
                    imem_wdata <= merged;
                end else begin
                    mask[beat_idx] <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/cpu_instr_loader.sv
// CPU bus to accelerator IMEM bridge: instruction assembly, control word,
// run/done sequencing and completion interrupt.
module cpu_instr_loader
    import cpu_bus_pkg::*;
#(
    parameter int BUS_W         = 32,
    parameter int INSTR_W       = 64,
    parameter int INSTR_NUM_BIT = 8,
    localparam int BEATS    = INSTR_W / BUS_W,
    localparam int BEAT_BIT = beat_bits(BEATS),
    localparam int ADDR_W   = INSTR_NUM_BIT + BEAT_BIT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     cpu_valid,
    output logic                     cpu_ready,
    input  logic [ADDR_W-1:0]        cpu_addr,
    input  logic [BUS_W-1:0]         cpu_data,
    output logic                     cpu_irq,
    output logic [3:0]               cpu_status,
    output logic                     imem_we,
    output logic [INSTR_NUM_BIT-1:0] imem_waddr,
    output logic [INSTR_W-1:0]       imem_wdata,
    output logic                     core_start,
    output logic [INSTR_NUM_BIT:0]   core_instr_count,
    input  logic                     core_done
);

    state_t                   state, state_nxt;
    logic                     start_nxt;
    logic                     err, err_nxt;
    logic                     xfer, is_ctrl, ctrl_xfer, instr_xfer;
    logic                     beat_wr, prog_clr_go;
    logic                     commit, incomplete;
    logic [BEAT_BIT-1:0]      beat_idx;
    logic [INSTR_NUM_BIT-1:0] instr_idx;
    logic [INSTR_NUM_BIT:0]   count_cand;
    logic                     prog_valid;

    // Bus decode
    always_comb begin
        xfer        = cpu_valid && cpu_ready;
        is_ctrl     = &cpu_addr;
        ctrl_xfer   = xfer && is_ctrl;
        instr_xfer  = xfer && !is_ctrl;
        beat_idx    = cpu_addr[BEAT_BIT-1:0];
        instr_idx   = cpu_addr[ADDR_W-1:BEAT_BIT];
        beat_wr     = instr_xfer && (state == IDLE);
        prog_clr_go = ctrl_xfer && cpu_data[CTRL_PROG_CLR] && (state != RUN);
        count_cand  = (INSTR_NUM_BIT+1)'(instr_idx) + (INSTR_NUM_BIT+1)'(1);
        prog_valid  = (core_instr_count != '0);
    end

    instr_assembler #(
        .BUS_W   (BUS_W),
        .INSTR_W (INSTR_W),
        .IDX_W   (INSTR_NUM_BIT)
    ) u_asm (
        .clk        (clk),
        .rst_n      (rst_n),
        .beat_wr    (beat_wr),
        .beat_idx   (beat_idx),
        .instr_idx  (instr_idx),
        .beat_data  (cpu_data),
        .mask_clr   (prog_clr_go),
        .commit     (commit),
        .incomplete (incomplete),
        .imem_we    (imem_we),
        .imem_waddr (imem_waddr),
        .imem_wdata (imem_wdata)
    );

    // Next state, start pulse and sticky error; a new error beats ERR_CLR
    always_comb begin
        state_nxt = state;
        start_nxt = 1'b0;
        err_nxt   = err;
        case (state)
            IDLE: begin
                if (ctrl_xfer && cpu_data[CTRL_START] && prog_valid) begin
                    state_nxt = RUN;
                    start_nxt = 1'b1;
                end
            end
            RUN: begin
                if (core_done) begin
                    state_nxt = DONE;
                end
            end
            DONE: begin
                if (ctrl_xfer && cpu_data[CTRL_START]) begin
                    state_nxt = RUN;
                    start_nxt = 1'b1;
                end else if (ctrl_xfer && cpu_data[CTRL_IRQ_CLR]) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (ctrl_xfer && cpu_data[CTRL_ERR_CLR]) begin
            err_nxt = 1'b0;
        end
        if (incomplete ||
            (instr_xfer && state == DONE) ||
            (ctrl_xfer && state == IDLE && cpu_data[CTRL_START] && !prog_valid)) begin
            err_nxt = 1'b1;
        end
    end

    // Control state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            core_start <= 1'b0;
            err        <= 1'b0;
        end else begin
            state      <= state_nxt;
            core_start <= start_nxt;
            err        <= err_nxt;
        end
    end

    // Program length tracks the highest instruction index written
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_instr_count <= '0;
        end else if (prog_clr_go) begin
            core_instr_count <= '0;
        end else if (commit && (count_cand > core_instr_count)) begin
            core_instr_count <= count_cand;
        end
    end

    assign cpu_ready  = (state != RUN);
    assign cpu_irq    = (state == DONE);
    assign cpu_status = {err, (state == RUN), (state == DONE), prog_valid};

endmodule
